// File: rtl/multi_evt_counter.sv
// Bank of independent up/down event counters with a programmable terminal value per channel.
// Each channel wraps or saturates at its boundary and emits a one-cycle registered terminal-count pulse.
module multi_evt_counter #(
    parameter  int NUM_CH    = 4,
    parameter  int MAX_COUNT = 64,
    parameter  int RST_VAL   = 0,
    parameter  int SATURATE  = 0,
    localparam int W         = $clog2(MAX_COUNT),
    localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 en_in,
    input  logic [NUM_CH-1:0]    evt_in,
    input  logic [NUM_CH-1:0]    dir_in,
    input  logic [NUM_CH-1:0]    clr_in,
    input  logic                 cfg_we_in,
    input  logic [CW-1:0]        cfg_ch_in,
    input  logic                 cfg_sel_in,
    input  logic [W-1:0]         cfg_val_in,
    output logic [NUM_CH*W-1:0]  count_out,
    output logic [NUM_CH-1:0]    tc_out
);

    localparam logic [W-1:0] RST_W = W'(RST_VAL);
    localparam logic [W-1:0] TOP_W = W'(MAX_COUNT - 1);
    localparam bit           SAT   = (SATURATE != 0);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [W-1:0] cnt_q, cnt_d;
        logic [W-1:0] top_q, top_d;
        logic         tc_q, tc_d;
        logic         hit;

        // Out-of-range channel numbers never match any channel, so such writes are dropped.
        assign hit = cfg_we_in && (cfg_ch_in == CW'(i));

        always_comb begin
            cnt_d = cnt_q;
            top_d = top_q;
            tc_d  = 1'b0;
            if (hit && cfg_sel_in) begin
                top_d = cfg_val_in;
            end
            if (clr_in[i]) begin
                cnt_d = RST_W;
            end else if (hit && !cfg_sel_in) begin
                cnt_d = cfg_val_in;
            end else if (en_in && evt_in[i]) begin
                // Boundary decisions use the current top; a same-cycle top write lands next cycle.
                if (dir_in[i]) begin
                    if (cnt_q >= top_q) begin
                        tc_d  = 1'b1;
                        cnt_d = SAT ? top_q : '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    if (cnt_q == '0) begin
                        tc_d  = 1'b1;
                        cnt_d = SAT ? '0 : top_q;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                cnt_q <= RST_W;
                top_q <= TOP_W;
                tc_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                top_q <= top_d;
                tc_q  <= tc_d;
            end
        end

        assign count_out[i*W +: W] = cnt_q;
        assign tc_out[i]           = tc_q;
    end

endmodule

// File: tb/tb_multi_evt_counter.sv
// Bench for multi_evt_counter: wrap and saturate builds driven in lockstep against a reference model,
// plus a three-channel build for out-of-range configuration writes.
module tb_multi_evt_counter;

    localparam int NUM_CH    = 4;
    localparam int MAX_COUNT = 64;
    localparam int RST_VAL   = 5;
    localparam int W         = 6;
    localparam int PW        = NUM_CH*W + NUM_CH;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [NUM_CH-1:0] evt, dir, clr;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic              cfg_sel;
    logic [W-1:0]      cfg_val;
    logic [NUM_CH*W-1:0] cnt_w, cnt_s;
    logic [NUM_CH-1:0]   tc_w, tc_s;

    logic        cfg_we3;
    logic [1:0]  cfg_ch3;
    logic [3:0]  cfg_val3;
    logic [11:0] cnt3;
    logic [2:0]  tc3;

    logic [PW-1:0] exp_q[$];
    logic [W-1:0]  m_cnt[2][NUM_CH];
    logic [W-1:0]  m_top[2][NUM_CH];
    int checks = 0;
    int errors = 0;
    int nstep  = 0;
    int tc_seen;
    logic [NUM_CH*W-1:0] rst_vec;

    multi_evt_counter #(.NUM_CH(NUM_CH), .MAX_COUNT(MAX_COUNT), .RST_VAL(RST_VAL), .SATURATE(0)) u_wrap (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .evt_in(evt), .dir_in(dir), .clr_in(clr),
        .cfg_we_in(cfg_we), .cfg_ch_in(cfg_ch), .cfg_sel_in(cfg_sel), .cfg_val_in(cfg_val),
        .count_out(cnt_w), .tc_out(tc_w));

    multi_evt_counter #(.NUM_CH(NUM_CH), .MAX_COUNT(MAX_COUNT), .RST_VAL(RST_VAL), .SATURATE(1)) u_sat (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .evt_in(evt), .dir_in(dir), .clr_in(clr),
        .cfg_we_in(cfg_we), .cfg_ch_in(cfg_ch), .cfg_sel_in(cfg_sel), .cfg_val_in(cfg_val),
        .count_out(cnt_s), .tc_out(tc_s));

    multi_evt_counter #(.NUM_CH(3), .MAX_COUNT(16), .RST_VAL(0), .SATURATE(0)) u_three (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(1'b0), .evt_in(3'b000), .dir_in(3'b000), .clr_in(3'b000),
        .cfg_we_in(cfg_we3), .cfg_ch_in(cfg_ch3), .cfg_sel_in(1'b0), .cfg_val_in(cfg_val3),
        .count_out(cnt3), .tc_out(tc3));

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        en = 1'b0; evt = '0; dir = '0; clr = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_sel = 1'b0; cfg_val = '0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NUM_CH; i++) begin
                m_cnt[d][i] = W'(RST_VAL);
                m_top[d][i] = W'(MAX_COUNT - 1);
            end
    endtask

    // Reference model: advance both builds by one edge and queue the expected outputs.
    task automatic model_push();
        logic [PW-1:0] e;
        logic          t;
        logic          me;
        logic [W-1:0]  c;
        logic [W-1:0]  tp;
        for (int d = 0; d < 2; d++) begin
            e = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                t  = 1'b0;
                me = cfg_we && (cfg_ch == 2'(i));
                c  = m_cnt[d][i];
                tp = m_top[d][i];
                if (clr[i]) c = W'(RST_VAL);
                else if (me && !cfg_sel) c = cfg_val;
                else if (en && evt[i]) begin
                    if (dir[i]) begin
                        if (m_cnt[d][i] >= tp) begin t = 1'b1; c = (d == 1) ? tp : '0; end
                        else c = m_cnt[d][i] + 1;
                    end else begin
                        if (m_cnt[d][i] == 0) begin t = 1'b1; c = (d == 1) ? '0 : tp; end
                        else c = m_cnt[d][i] - 1;
                    end
                end
                if (me && cfg_sel) m_top[d][i] = cfg_val;
                m_cnt[d][i] = c;
                e[i*W +: W] = c;
                e[NUM_CH*W + i] = t;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        logic [PW-1:0] e;
        nstep++;
        model_push();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("wrap count step%0d", nstep), 32'(cnt_w), 32'(e[NUM_CH*W-1:0]));
        check($sformatf("wrap tc step%0d", nstep), 32'(tc_w), 32'(e[PW-1:NUM_CH*W]));
        e = exp_q.pop_front();
        check($sformatf("sat count step%0d", nstep), 32'(cnt_s), 32'(e[NUM_CH*W-1:0]));
        check($sformatf("sat tc step%0d", nstep), 32'(tc_s), 32'(e[PW-1:NUM_CH*W]));
    endtask

    task automatic cfg(input logic [1:0] ch, input logic sel, input logic [W-1:0] val);
        idle();
        cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_val = val;
        step();
    endtask

    task automatic event_on(input int ch, input logic up);
        idle();
        en = 1'b1; evt[ch] = 1'b1; dir[ch] = up;
        step();
    endtask

    initial begin
        rst_vec = {NUM_CH{6'(RST_VAL)}};
        idle();
        cfg_we3 = 1'b0; cfg_ch3 = '0; cfg_val3 = '0;
        rst_n = 1'b1;

        // Reset dropped between edges takes effect immediately
        #2 rst_n = 1'b0;
        #1;
        check("reset wrap count", 32'(cnt_w), 32'(rst_vec));
        check("reset sat count", 32'(cnt_s), 32'(rst_vec));
        check("reset wrap tc", 32'(tc_w), 32'd0);
        check("reset sat tc", 32'(tc_s), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Top reads back as 63: from 63 an up event is a boundary event
        cfg(2'd1, 1'b0, 6'd63);
        event_on(1, 1'b1);
        check("top63 wrap ch1", 32'(cnt_w[11:6]), 32'd0);
        check("top63 sat ch1", 32'(cnt_s[11:6]), 32'd63);

        // Wrap up on ch0 with top 9
        cfg(2'd0, 1'b1, 6'd9);
        cfg(2'd0, 1'b0, 6'd0);
        tc_seen = 0;
        for (int k = 0; k < 12; k++) begin
            event_on(0, 1'b1);
            if (tc_w[0]) tc_seen++;
        end
        check("wrap12 final ch0", 32'(cnt_w[5:0]), 32'd2);
        check("wrap12 tc pulses", 32'(tc_seen), 32'd1);

        // Down from zero on ch1, twice
        cfg(2'd1, 1'b0, 6'd0);
        event_on(1, 1'b0);
        check("down0 wrap ch1", 32'(cnt_w[11:6]), 32'd63);
        check("down0 wrap tc", 32'(tc_w[1]), 32'd1);
        check("down0 sat ch1", 32'(cnt_s[11:6]), 32'd0);
        check("down0 sat tc", 32'(tc_s[1]), 32'd1);
        event_on(1, 1'b0);

        // Priority on ch2: clear beats count write beats event
        idle();
        clr[2] = 1'b1; en = 1'b1; evt[2] = 1'b1; dir[2] = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_sel = 1'b0; cfg_val = 6'd20;
        step();
        check("prio clr ch2", 32'(cnt_w[17:12]), 32'(RST_VAL));
        clr[2] = 1'b0;
        step();
        check("prio cfg ch2", 32'(cnt_w[17:12]), 32'd20);

        // Top write with same-cycle event on ch0 uses the old top
        cfg(2'd0, 1'b0, 6'd2);
        idle();
        en = 1'b1; evt[0] = 1'b1; dir[0] = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = 1'b1; cfg_val = 6'd3;
        step();
        check("old top ch0", 32'(cnt_w[5:0]), 32'd3);
        event_on(0, 1'b1);

        // Count written above top, then up event
        cfg(2'd0, 1'b0, 6'd7);
        event_on(0, 1'b1);
        check("above top sat ch0", 32'(cnt_s[5:0]), 32'd3);

        // Top = 0 on ch3: every counted event is a boundary
        cfg(2'd3, 1'b1, 6'd0);
        cfg(2'd3, 1'b0, 6'd0);
        for (int k = 0; k < 3; k++) event_on(3, 1'b1);
        event_on(3, 1'b0);

        // Gating and independence
        idle();
        evt = '1; dir = 4'b1010;
        step();
        idle();
        en = 1'b1; evt = 4'b1000; dir = 4'b1000;
        step();

        // Random traffic
        for (int k = 0; k < 40; k++) begin
            en      = ($urandom_range(0, 3) != 0);
            evt     = 4'($urandom_range(0, 15));
            dir     = 4'($urandom_range(0, 15));
            clr     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            cfg_we  = ($urandom_range(0, 3) == 0);
            cfg_ch  = 2'($urandom_range(0, 3));
            cfg_sel = 1'($urandom_range(0, 1));
            cfg_val = 6'($urandom_range(0, 63));
            step();
        end

        // Out-of-range channel on a three-channel build
        idle();
        cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_val3 = 4'd9;
        @(posedge clk); #1;
        check("oor write three", 32'(cnt3), 32'd0);
        cfg_ch3 = 2'd2; cfg_val3 = 4'd7;
        @(posedge clk); #1;
        check("inrange write three", 32'(cnt3), 32'h700);
        cfg_we3 = 1'b0;

        // Reset mid-operation discards in-flight activity
        @(negedge clk);
        en = 1'b1; evt = '1; dir = '1; clr = 4'b0100;
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_sel = 1'b0; cfg_val = 6'd40;
        #2 rst_n = 1'b0;
        #1;
        check("midreset wrap count", 32'(cnt_w), 32'(rst_vec));
        check("midreset sat count", 32'(cnt_s), 32'(rst_vec));
        check("midreset three", 32'(cnt3), 32'd0);
        @(posedge clk); #1;
        check("held reset wrap count", 32'(cnt_w), 32'(rst_vec));
        check("held reset tc", 32'(tc_w), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle();
        en = 1'b1; evt[0] = 1'b1; dir[0] = 1'b1;
        step();
        check("first edge after reset", 32'(cnt_w[5:0]), 32'(RST_VAL + 1));
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_evt_counter.md
MULTI_EVT_COUNTER -- requirements
Module: multi_evt_counter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent counter channels (>=1).
REQ-002 SHALL have parameter MAX_COUNT, default 64, counter range; W = $clog2(MAX_COUNT), MAX_COUNT >= 2.
REQ-003 SHALL have parameter RST_VAL, default 0, count value after reset or clear (< MAX_COUNT).
REQ-004 SHALL have parameter SATURATE, default 0; 0 = wrap mode, 1 = saturate mode, applied to all channels.
REQ-005 SHALL have port clk_in  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n_in  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port en_in  input  1  global count enable; events ignored when low.
REQ-008 SHALL have port evt_in  input  NUM_CH  per-channel event strobe, one count per high cycle.
REQ-009 SHALL have port dir_in  input  NUM_CH  per-channel direction, 1 = up, 0 = down.
REQ-010 SHALL have port clr_in  input  NUM_CH  per-channel synchronous clear to RST_VAL.
REQ-011 SHALL have port cfg_we_in  input  1  configuration write strobe.
REQ-012 SHALL have port cfg_ch_in  input  max(1,$clog2(NUM_CH))  channel targeted by the write.
REQ-013 SHALL have port cfg_sel_in  input  1  write target, 0 = count, 1 = top (terminal value).
REQ-014 SHALL have port cfg_val_in  input  W  value written.
REQ-015 SHALL have port count_out  output  NUM_CH*W  packed counts, channel i at bits [i*W +: W].
REQ-016 SHALL have port tc_out  output  NUM_CH  per-channel terminal-count pulse.

Function
REQ-017 Each channel SHALL hold a W-bit count and a W-bit top register; top resets to MAX_COUNT-1.
REQ-018 Count update SHALL take effect at the clock edge where the causing input is sampled (latency 1); count_out is a direct register output.
REQ-019 Per-channel priority SHALL be: clr_in > cfg write to that channel's count > event; lower-priority actions in the same cycle are discarded.
REQ-020 A cfg write to top SHALL not block a same-cycle event; that event uses the old top, the new top applies from the next cycle.
REQ-021 Event counted SHALL require en_in=1 and evt_in[i]=1; otherwise count holds.
REQ-022 Up, count < top: count+1; count >= top: wrap mode -> 0, saturate mode -> top.
REQ-023 Down, count > 0: count-1; count == 0: wrap mode -> top, saturate mode -> hold at 0.
REQ-024 Writes to count SHALL store cfg_val_in unmodified, even if above top; subsequent up event follows REQ-022.
REQ-025 cfg_ch_in >= NUM_CH SHALL make the write a no-op.
REQ-026 tc_out[i] SHALL be registered, high for exactly one cycle, asserted on the same edge the count takes its boundary action (up at/above top, down at 0), in both modes; repeated boundary events give a pulse per event.
REQ-027 clr_in and cfg writes SHALL never assert tc_out.
REQ-028 Arithmetic SHALL be W-bit modulo-free: no intermediate overflow reaches count_out; top = 0 makes every counted event a boundary event (count stays 0, tc pulses).
REQ-029 Channels SHALL be fully independent except for shared en_in and the cfg port.

Reset
REQ-030 rst_n_in low SHALL asynchronously set every count to RST_VAL, every top to MAX_COUNT-1, and tc_out to 0, regardless of clock.
REQ-031 Reset assertion mid-operation SHALL discard any in-flight event, clear, or cfg write; first counting edge is the first rising edge with rst_n_in high.

Verification
REQ-032 Reset: NUM_CH=4, MAX_COUNT=64, RST_VAL=5, drop rst_n_in between edges -> count_out channels all 5 immediately, tc_out=0, top reads back as 63 via wrap behaviour.
REQ-033 Wrap up: ch0 top=9, 12 up events -> counts 1..9,0,1,2 from 0; tc_out[0] single pulse on the 9->0 edge.
REQ-034 Wrap/saturate down: ch1 count=0, down event -> wrap build: 63 with tc pulse; SATURATE=1 build: stays 0 with tc pulse.
REQ-035 Priority: ch2 same cycle clr_in, cfg count write 20, event up -> count = RST_VAL; next cycle cfg write 20 + event -> 20.
REQ-036 Gating and independence: en_in=0 with all evt_in high -> no change; en_in=1, ch3 events, others idle -> only ch3 changes; cfg_ch_in out of range -> no channel changes.
